systolic_seq_ctrl: RTL and testbench

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

---
 rtl/systolic_pkg.sv | 31 +++
 rtl/seq_delay_line.sv | 47 ++++
 rtl/systolic_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic-array sequencer.
//
// Contents:
//   seq_state_e  - sequencer FSM state encoding
//   WLOAD_*      - weight-interface load codes driven on w_load
//   max3         - helper used to size the phase counter
package systolic_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoadLo = 3'd1,
        StStream = 3'd2,
        StLoadHi = 3'd3,
        StFeed   = 3'd4,
        StDrain  = 3'd5,
        StDone   = 3'd6
    } seq_state_e;

    localparam logic [2:0] WLOAD_NONE = 3'b000;
    localparam logic [2:0] WLOAD_LO   = 3'b001;
    localparam logic [2:0] WLOAD_HI   = 3'b010;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_delay_line.sv
// Single-bit delay line with synchronous clear.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (empties the line)
//   clr   - synchronous clear of every stage
//   d     - input bit
//   q     - d delayed by DEPTH cycles (combinational pass-through when DEPTH == 0)
module seq_delay_line #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    if (DEPTH == 0) begin : g_bypass
        assign q = d;
    end else begin : g_shift
        logic [DEPTH-1:0] sr_q;
        logic [DEPTH-1:0] sr_d;

        // Stage 0 takes d; stage i takes stage i-1.
        always_comb begin
            sr_d = '0;
            if (!clr) begin
                sr_d[0] = d;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_q <= '0;
            end else begin
                sr_q <= sr_d;
            end
        end

        assign q = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Layer sequencer for a weight-stationary systolic MAC array.
//
// Per layer: load lower weight half, let the weight skew stream through the
// columns, load upper half while clearing accumulators, feed N_INPUTS input
// words, then drain the array and flag the layer result. N_LAYERS layers run
// back to back per start, followed by a one-cycle done pulse.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - begin a run (sampled only while idle)
//   abort      - synchronous cancel back to idle (wins over everything)
//   w_load     - weight load code (WLOAD_NONE / WLOAD_LO / WLOAD_HI)
//   in_load_en - advance input-memory address
//   mac_en     - array enable, in_load_en delayed by the input read latency
//   acc_clr    - one-cycle accumulator clear
//   out_valid  - one-cycle pulse when a layer result is ready
//   layer_idx  - current layer index
//   busy       - high whenever not idle
//   done       - one-cycle pulse at run completion
//
// Assumes N_LAYERS >= 2, N_INPUTS >= 1 and IN_LAT + DRAIN_CYC >= 1.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N_MACS    = 4,
    parameter int unsigned N_LAYERS  = 4,
    parameter int unsigned N_INPUTS  = 8,
    parameter int unsigned IN_LAT    = 2,
    parameter int unsigned DRAIN_CYC = N_MACS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    output logic [2:0]                  w_load,
    output logic                        in_load_en,
    output logic                        mac_en,
    output logic                        acc_clr,
    output logic                        out_valid,
    output logic [$clog2(N_LAYERS)-1:0] layer_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned STREAM_LEN = N_MACS + 1;
    localparam int unsigned FEED_LEN   = N_INPUTS;
    localparam int unsigned DRAIN_LEN  = IN_LAT + DRAIN_CYC;
    localparam int unsigned MAX_LEN    = max3(STREAM_LEN, FEED_LEN, DRAIN_LEN);
    localparam int unsigned CNT_W      = $clog2(MAX_LEN + 1);
    localparam int unsigned LIDX_W     = $clog2(N_LAYERS);

    localparam logic [CNT_W-1:0]  STREAM_LAST = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0]  FEED_LAST   = CNT_W'(FEED_LEN - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST  = CNT_W'(DRAIN_LEN - 1);
    localparam logic [LIDX_W-1:0] LAYER_LAST  = LIDX_W'(N_LAYERS - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LIDX_W-1:0] layer_q, layer_d;

    logic [2:0] w_load_q, w_load_d;
    logic       in_load_en_q, in_load_en_d;
    logic       acc_clr_q, acc_clr_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next state, phase counter and layer index. cnt counts cycles spent in
    // the current phase and restarts at 0 on every phase entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        layer_d = layer_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    state_d = StLoadLo;
                end
            end
            StLoadLo: begin
                state_d = StStream;
                cnt_d   = '0;
            end
            StStream: begin
                if (cnt_q == STREAM_LAST) begin
                    state_d = StLoadHi;
                    cnt_d   = '0;
                end
            end
            StLoadHi: begin
                state_d = StFeed;
                cnt_d   = '0;
            end
            StFeed: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    if (layer_q == LAYER_LAST) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLoadLo;
                        layer_d = layer_q + LIDX_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
                layer_d = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                layer_d = '0;
            end
        endcase

        // Abort overrides every transition, including start from idle.
        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
            layer_d = '0;
        end
    end

    // Outputs are decoded from the next state so they appear registered and
    // aligned with the state they describe.
    always_comb begin
        unique case (state_d)
            StLoadLo: w_load_d = WLOAD_LO;
            StLoadHi: w_load_d = WLOAD_HI;
            default:  w_load_d = WLOAD_NONE;
        endcase
        in_load_en_d = (state_d == StFeed);
        acc_clr_d    = (state_d == StLoadHi);
        out_valid_d  = (state_d == StDrain) && (cnt_d == DRAIN_LAST);
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            layer_q      <= '0;
            w_load_q     <= WLOAD_NONE;
            in_load_en_q <= 1'b0;
            acc_clr_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            layer_q      <= layer_d;
            w_load_q     <= w_load_d;
            in_load_en_q <= in_load_en_d;
            acc_clr_q    <= acc_clr_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // mac_en tracks in_load_en shifted by the input-memory read latency; abort
    // flushes any in-flight enables so the array stops immediately.
    seq_delay_line #(
        .DEPTH (IN_LAT)
    ) u_mac_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort),
        .d     (in_load_en_q),
        .q     (mac_en)
    );

    assign w_load     = w_load_q;
    assign in_load_en = in_load_en_q;
    assign acc_clr    = acc_clr_q;
    assign out_valid  = out_valid_q;
    assign layer_idx  = layer_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed scenarios followed by random
// start/abort/reset traffic, checked against a timeline model and an event
// scoreboard for out_valid and done pulses.
module tb_systolic_seq_ctrl;

    localparam int N_MACS    = 4;
    localparam int N_LAYERS  = 4;
    localparam int N_INPUTS  = 8;
    localparam int IN_LAT    = 2;
    localparam int DRAIN_CYC = 4;
    localparam int P         = N_MACS + N_INPUTS + IN_LAT + DRAIN_CYC + 3;
    localparam int LW        = $clog2(N_LAYERS);
    localparam int VW        = 3 + 6 + LW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    w_load;
    logic          in_load_en;
    logic          mac_en;
    logic          acc_clr;
    logic          out_valid;
    logic [LW-1:0] layer_idx;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(
        .N_MACS    (N_MACS),
        .N_LAYERS  (N_LAYERS),
        .N_INPUTS  (N_INPUTS),
        .IN_LAT    (IN_LAT),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .w_load     (w_load),
        .in_load_en (in_load_en),
        .mac_en     (mac_en),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .layer_idx  (layer_idx),
        .busy       (busy),
        .done       (done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n     = 0;  // cycle index, advanced on every rising edge

    // Reference model: a run is fully described by whether it is active and
    // the cycle its first LOAD_LO occupies.
    bit m_active = 1'b0;
    int m_base   = 0;

    typedef struct {
        int cyc;
        int layer;
    } ev_t;

    ev_t ov_q[$];
    int  done_q[$];

    // Expected outputs k cycles after the first LOAD_LO of an active run.
    function automatic logic [VW-1:0] exp_vec(input bit act, input int k);
        logic [2:0] wl;
        logic ile, me, ac, ov, bz, dn;
        int lay, pos;
        wl = 3'b000; ile = 0; me = 0; ac = 0; ov = 0; bz = 0; dn = 0; lay = 0;
        if (act) begin
            bz = 1'b1;
            if (k >= N_LAYERS * P) begin
                dn  = 1'b1;
                lay = N_LAYERS - 1;
            end else begin
                lay = k / P;
                pos = k % P;
                if (pos == 0) wl = 3'b001;
                if (pos == N_MACS + 2) begin
                    wl = 3'b010;
                    ac = 1'b1;
                end
                ile = (pos >= N_MACS + 3) && (pos < N_MACS + 3 + N_INPUTS);
                me  = (pos >= N_MACS + 3 + IN_LAT) && (pos < N_MACS + 3 + IN_LAT + N_INPUTS);
                ov  = (pos == P - 1);
            end
        end
        return {wl, ile, me, ac, ov, bz, dn, LW'(lay)};
    endfunction

    // Model update on each rising edge; pushes expected pulse events on start.
    always @(posedge clk) begin
        n = n + 1;
        if (!rst_n) begin
            m_active = 1'b0;
            ov_q.delete();
            done_q.delete();
        end else if (m_active) begin
            if (abort) begin
                m_active = 1'b0;
                ov_q.delete();
                done_q.delete();
            end else if (n == m_base + N_LAYERS * P + 1) begin
                m_active = 1'b0;
            end
        end else if (start && !abort) begin
            m_active = 1'b1;
            m_base   = n;
            for (int l = 0; l < N_LAYERS; l++) begin
                ov_q.push_back('{cyc: m_base + l * P + P - 1, layer: l});
            end
            done_q.push_back(m_base + N_LAYERS * P);
        end
    end

    // Monitor: full output vector every cycle, plus scoreboard pops on pulses.
    always @(negedge clk) begin : mon
        logic [VW-1:0] got;
        logic [VW-1:0] exp;
        ev_t ev;
        int  dc;
        got = {w_load, in_load_en, mac_en, acc_clr, out_valid, busy, done, layer_idx};
        exp = exp_vec(m_active, n - m_base);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL outputs cycle %0d: got %h expected %h", n, got, exp);
        end
        if (ov_q.size() > 0 && ov_q[0].cyc < n) begin
            ev = ov_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL out_valid missed: got no pulse, expected at cycle %0d", ev.cyc);
        end
        if (done_q.size() > 0 && done_q[0] < n) begin
            dc = done_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL done missed: got no pulse, expected at cycle %0d", dc);
        end
        if (out_valid === 1'b1) begin
            n_cmp++;
            if (ov_q.size() == 0) begin
                n_err++;
                $display("FAIL out_valid unexpected at cycle %0d, none expected", n);
            end else begin
                ev = ov_q.pop_front();
                if (ev.cyc != n || ev.layer != int'(layer_idx)) begin
                    n_err++;
                    $display("FAIL out_valid event: got cycle %0d layer %0d expected %0d/%0d",
                             n, layer_idx, ev.cyc, ev.layer);
                end
            end
        end
        if (done === 1'b1) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_err++;
                $display("FAIL done unexpected at cycle %0d, none expected", n);
            end else begin
                dc = done_q.pop_front();
                if (dc != n) begin
                    n_err++;
                    $display("FAIL done event: got cycle %0d expected cycle %0d", n, dc);
                end
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Assert reset mid-cycle (after the sampling edge) and check outputs
    // drop without waiting for a clock; release one cycle later.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({w_load, in_load_en, mac_en, acc_clr, out_valid, busy, done, layer_idx} !== '0) begin
            n_err++;
            $display("FAIL async reset: got %h expected 0",
                     {w_load, in_load_en, mac_en, acc_clr, out_valid, busy, done, layer_idx});
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({w_load, in_load_en, mac_en, acc_clr, out_valid, busy, done, layer_idx} !== '0) begin
            n_err++;
            $display("FAIL reset state: got %h expected 0",
                     {w_load, in_load_en, mac_en, acc_clr, out_valid, busy, done, layer_idx});
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Single start pulse, full run.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(100);

        // Start held high: back-to-back runs through DONE -> IDLE -> LOAD_LO.
        start = 1'b1; cyc(200); start = 1'b0;
        cyc(100);

        // Abort 12 cycles after the start cycle, inside FEED.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(11);
        abort = 1'b1; cyc(1); abort = 1'b0;
        cyc(30);

        // Start pulsed mid-run must be ignored.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(28);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(100);

        // Asynchronous reset during STREAM, then an immediate restart.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(3);
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(100);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 699) == 0) begin
                start = 1'b0;
                abort = 1'b0;
                do_reset();
            end else begin
                cyc(1);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        cyc(100);

        n_cmp++;
        if (ov_q.size() != 0) begin
            n_err++;
            $display("FAIL pending out_valid: got %0d left expected 0", ov_q.size());
        end
        n_cmp++;
        if (done_q.size() != 0) begin
            n_err++;
            $display("FAIL pending done: got %0d left expected 0", done_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
